// File: rtl/bp_pkg.sv
// Shared definitions for the back-pressure aggregator: channel state encoding,
// counter widths and the popcount used to tally simultaneous fault entries.
package bp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10,
        ST_FAULT  = 2'b11
    } ch_state_t;

    localparam int WAIT_W = 8;
    localparam int HOLD_W = 4;
    localparam int MAX_CH = 16;

    function automatic logic [4:0] popcount16(input logic [MAX_CH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_channel.sv
// One channel of the aggregator: IDLE/ACTIVE/STALL/FAULT machine with a wait
// timeout counter and a back-pressure hold counter.
module bp_channel
    import bp_pkg::*;
#(
    parameter int unsigned HOLD    = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      error,
    input  logic      wait_req,
    input  logic      valid,
    input  logic      clear,
    output ch_state_t state,
    output logic      bp_w,
    output logic      fault_entry
);

    ch_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_hit;
    logic              busy_q;

    assign busy_q      = (state_q == ST_STALL) || (state_q == ST_FAULT);
    assign timeout_hit = ({1'b0, wait_q} + 9'd1) == 9'(TIMEOUT);

    // wait_d defaults to zero so the counter only survives while staying in STALL
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        hold_d  = hold_q;
        if (clear) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            if (busy_q) begin
                hold_d = HOLD_W'(HOLD);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end
            if (error) begin
                state_d = ST_FAULT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid) state_d = ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (wait_req)   state_d = ST_STALL;
                        else if (!valid) state_d = ST_IDLE;
                    end
                    ST_STALL: begin
                        if (!wait_req) begin
                            state_d = valid ? ST_ACTIVE : ST_IDLE;
                        end else if (timeout_hit) begin
                            state_d = ST_FAULT;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                    ST_FAULT: state_d = ST_FAULT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
        end
    end

    assign state       = state_q;
    assign bp_w        = busy_q || (hold_q != '0);
    assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);

endmodule

// File: rtl/bp_aggregator.sv
// Back-pressure aggregator top: per-channel machines reduced to a global write
// back-pressure (OR), read-ready (AND) and a saturating fault-entry count.
module bp_aggregator
    import bp_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned HOLD     = 3,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [CHANNELS-1:0] Error,
    input  logic [CHANNELS-1:0] Wait,
    input  logic [CHANNELS-1:0] Valid,
    input  logic [CHANNELS-1:0] Clear,
    output logic [CHANNELS-1:0] ChBpW,
    output logic [CHANNELS-1:0] Fault,
    output logic                BpW,
    output logic                BpR,
    output logic [7:0]          FaultCount
);

    ch_state_t           ch_state [CHANNELS];
    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] entry;
    logic [7:0]          count_q;
    logic [8:0]          sum;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        bp_channel #(
            .HOLD    (HOLD),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk         (Clk),
            .rst         (Rst),
            .error       (Error[g]),
            .wait_req    (Wait[g]),
            .valid       (Valid[g]),
            .clear       (Clear[g]),
            .state       (ch_state[g]),
            .bp_w        (ChBpW[g]),
            .fault_entry (entry[g])
        );
        assign Fault[g] = (ch_state[g] == ST_FAULT);
        assign ready[g] = (ch_state[g] == ST_IDLE) || (ch_state[g] == ST_ACTIVE);
    end

    // Several channels may fault on one edge, so the count adds a popcount
    assign sum = {1'b0, count_q} + 9'(popcount16(MAX_CH'(entry)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
        end else begin
            count_q <= sum[8] ? 8'hFF : sum[7:0];
        end
    end

    assign BpW        = |ChBpW;
    assign BpR        = &ready;
    assign FaultCount = count_q;

endmodule

// File: doc/bp_aggregator.md
# bp_aggregator

Multi-channel bus back-pressure aggregator: the parametrised, clocked successor to the team's combinational wired-OR/wired-AND back-pressure gates. Each of CHANNELS channels runs a small state machine on its Error/Wait/Valid/Clear inputs. The machine adds sticky faults, a wait timeout and a minimum back-pressure hold. Per-channel results are reduced to a global write back-pressure (OR) and a global read-ready (AND). The block sits between the channel status sources and the bus arbiter.

## Interface
- CHANNELS, 4: number of independent channels, 1..16.
- HOLD, 3: cycles ChBpW stays high after a channel leaves STALL/FAULT, 0..15.
- TIMEOUT, 15: consecutive STALL cycles with Wait=1 before FAULT, 1..255.

- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Error  in  CHANNELS  per-channel error.
- Wait  in  CHANNELS  per-channel wait request.
- Valid  in  CHANNELS  per-channel transfer valid.
- Clear  in  CHANNELS  per-channel clear; highest priority.
- ChBpW  out  CHANNELS  per-channel write back-pressure.
- Fault  out  CHANNELS  1 while channel state is FAULT.
- BpW  out  1  OR of ChBpW.
- BpR  out  1  AND over channels of (state is IDLE or ACTIVE).
- FaultCount  out  8  saturating count of FAULT entries since reset.

## Operation
- Per-channel states: IDLE=2'b00, ACTIVE=2'b01, STALL=2'b10, FAULT=2'b11.
- Transition priority per edge:
  1. Clear → IDLE from any state; wait_cnt=0, hold_cnt=0.
  2. Else Error → FAULT from any state.
  3. Else FAULT stays FAULT. It exits only via Clear or Rst.
  4. IDLE: Valid → ACTIVE, else stay.
  5. ACTIVE: Wait → STALL; else !Valid → IDLE; else stay.
  6. STALL: !Wait → ACTIVE if Valid, else IDLE. With Wait=1, wait_cnt increments. FAULT is entered on the edge where wait_cnt+1 == TIMEOUT.
- wait_cnt is 0 whenever the state is not STALL.
- hold_cnt (4 bit):
  - Loads HOLD on every edge whose pre-edge state is STALL or FAULT (unless Clear).
  - Otherwise decrements and saturates at 0.
- ChBpW[i] = (state is STALL or FAULT) or hold_cnt != 0.
- FaultCount adds, each edge, the number of channels entering FAULT on that edge (popcount, not 0/1). It saturates at 255 and is cleared only by Rst.
- All outputs are decoded from registers only; there is no combinational input→output path.

## Timing
- Reset values:
  - States IDLE; wait_cnt 0; hold_cnt 0.
  - ChBpW 0, Fault 0, BpW 0, BpR 1, FaultCount 0.
- Latency: an input sampled at edge k is reflected in the outputs from cycle k+1 onward.
- Entering STALL/FAULT raises ChBpW/BpW and drops BpR in the same cycle the state changes.
- After leaving STALL/FAULT without Clear, ChBpW stays high exactly HOLD further cycles. HOLD=0 means it drops with the state.
- Clear drops ChBpW and raises the channel's BpR contribution on the next cycle, regardless of hold_cnt.
- Clear and Error on the same cycle: Clear wins and no fault is counted.
- Error while already in FAULT: no new entry is counted.
- Rst mid-operation: all state returns to reset values on the next cycle and inputs are ignored that edge.
- TIMEOUT example: Valid=Wait=1 held from cycle 0 gives ACTIVE in 1, STALL in 2..TIMEOUT+1, FAULT in TIMEOUT+2.

## Structure
- Package bp_pkg:
  - State encoding constants.
  - Counter widths: wait_cnt = 8 bit, hold_cnt = 4 bit.
  - Popcount function for FaultCount.
- Sub-module bp_channel:
  - One FSM with its wait_cnt and hold_cnt.
  - Outputs state, ChBpW bit and fault-entry pulse.
  - Instantiated CHANNELS times via generate.
- Top level: OR/AND reductions and the FaultCount adder/saturator.

## Test plan
All cases use default parameters unless stated.
- Reset: Rst high 2 cycles with random inputs → BpW=0, BpR=1, ChBpW=0, Fault=0, FaultCount=0.
- Stall and hold: ch0 Valid=1, Wait=1 for 3 cycles, then Wait=0.
  - ch0 goes ACTIVE, STALL×3, ACTIVE.
  - ChBpW[0] high during STALL plus 3 more cycles.
  - BpR=0 only during STALL.
- Timeout: ch2 Valid=Wait=1 held.
  - Fault[2]=1 from cycle 17, FaultCount=1.
  - BpR stays 0 until Clear[2] is pulsed, then BpR=1 and ChBpW[2]=0 the following cycle.
- Simultaneous events: Error on ch0..ch3 in the same cycle → FaultCount +4 in one step.
- Priority: Clear[1] and Error[1] on the same cycle → ch1 IDLE, FaultCount unchanged.
- Saturation: CHANNELS=4 with 70 rounds of 4-channel Error/Clear → FaultCount holds at 255.
- Mid-operation reset: Rst asserted while in STALL → all reset values the next cycle.
